ft_bus_stall_mon: RTL and testbench

FT_BUS_STALL_MON -- requirements
Module: ft_bus_stall_mon

---
 rtl/ft_bus_stall_mon_if.sv | 14 +
 rtl/ft_bus_stall_mon.sv | 118 +++++++++++
 tb/tb_ft_bus_stall_mon.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft_bus_stall_mon_if.sv
// Bundle of per-channel Wishbone handshake lines; bit i of every vector belongs to channel i.
// The monitor modport is a passive tap that only observes the bus.
interface ft_bus_stall_mon_if #(
  parameter int NUM_CH = 2
) ();
  logic [NUM_CH-1:0] cyc;
  logic [NUM_CH-1:0] stb;
  logic [NUM_CH-1:0] ack;
  logic [NUM_CH-1:0] we;

  modport master  (output cyc, output stb, output we, input  ack);
  modport slave   (input  cyc, input  stb, input  we, output ack);
  modport monitor (input  cyc, input  stb, input  we, input  ack);
endinterface

// File: rtl/ft_bus_stall_mon.sv
// Per-channel Wishbone stall monitor: tracks outstanding requests, flags stalls, and keeps
// saturating stall/transfer counters plus the longest contiguous stall run per channel.
module ft_bus_stall_mon #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int RUN_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  ft_bus_stall_mon_if.monitor     wb_bus,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic                    cnt_clear,
  output logic [NUM_CH-1:0]       bus_write,
  output logic [NUM_CH-1:0]       bus_read,
  output logic [NUM_CH-1:0]       bus_stall,
  output logic                    freeze,
  output logic [NUM_CH*CNT_W-1:0] stall_cnt,
  output logic [NUM_CH*CNT_W-1:0] xfer_cnt,
  output logic [NUM_CH*RUN_W-1:0] max_run,
  output logic [NUM_CH-1:0]       cnt_overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e state_q [NUM_CH];
  state_e state_d [NUM_CH];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
    end
  end

  // NOTE: each next-state entry is defaulted to hold before the case, so no path leaves
  // state_d unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: if (wb_bus.cyc[i] && wb_bus.stb[i] && !wb_bus.ack[i]) state_d[i] = PEND;
        PEND: if (wb_bus.ack[i] || !wb_bus.cyc[i])                  state_d[i] = IDLE;
      endcase
    end
  end

  // A stall is only flagged once a request has already waited one cycle; stb dropping
  // while cyc is held keeps the channel pending.
  always_comb begin
    bus_stall = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus_stall[i] = (state_q[i] == PEND) && wb_bus.cyc[i] && !wb_bus.ack[i];
    end
  end

  assign bus_write = wb_bus.cyc & wb_bus.stb &  wb_bus.we;
  assign bus_read  = wb_bus.cyc & wb_bus.stb & ~wb_bus.we;
  assign freeze    = |(bus_stall & ch_enable);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             stall_inc;
    logic             xfer_inc;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] xfer_q;
    logic [RUN_W-1:0] cur_run_q;
    logic [RUN_W-1:0] max_run_q;
    logic [RUN_W-1:0] run_inc;
    logic             ovf_q;

    assign stall_inc = bus_stall[g] & ch_enable[g];
    assign xfer_inc  = wb_bus.cyc[g] & wb_bus.stb[g] & wb_bus.ack[g] & ch_enable[g];
    assign run_inc   = (&cur_run_q) ? cur_run_q : cur_run_q + RUN_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        stall_q   <= '0;
        xfer_q    <= '0;
        cur_run_q <= '0;
        max_run_q <= '0;
        ovf_q     <= 1'b0;
      end else if (cnt_clear) begin
        stall_q   <= '0;
        xfer_q    <= '0;
        cur_run_q <= '0;
        max_run_q <= '0;
        ovf_q     <= 1'b0;
      end else begin
        if (stall_inc) begin
          if (&stall_q) ovf_q   <= 1'b1;
          else          stall_q <= stall_q + CNT_W'(1);
        end
        if (xfer_inc) begin
          if (&xfer_q) ovf_q  <= 1'b1;
          else         xfer_q <= xfer_q + CNT_W'(1);
        end
        // max_run tracks the run while it grows, not only when it ends.
        if (stall_inc) begin
          cur_run_q <= run_inc;
          if (run_inc > max_run_q) max_run_q <= run_inc;
        end else begin
          cur_run_q <= '0;
        end
      end
    end

    assign stall_cnt[g*CNT_W +: CNT_W] = stall_q;
    assign xfer_cnt[g*CNT_W +: CNT_W]  = xfer_q;
    assign max_run[g*RUN_W +: RUN_W]   = max_run_q;
    assign cnt_overflow[g]             = ovf_q;
  end

endmodule

// File: tb/tb_ft_bus_stall_mon.sv
// Directed bench for ft_bus_stall_mon: hand-computed stall/transfer/run expectations,
// saturation, clear priority and asynchronous reset mid-run.
module tb_ft_bus_stall_mon;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;
  localparam int RUN_W  = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ft_bus_stall_mon_if #(.NUM_CH(NUM_CH)) wb_bus ();

  logic [NUM_CH-1:0]       ch_enable;
  logic                    cnt_clear;
  logic [NUM_CH-1:0]       bus_write;
  logic [NUM_CH-1:0]       bus_read;
  logic [NUM_CH-1:0]       bus_stall;
  logic                    freeze;
  logic [NUM_CH*CNT_W-1:0] stall_cnt;
  logic [NUM_CH*CNT_W-1:0] xfer_cnt;
  logic [NUM_CH*RUN_W-1:0] max_run;
  logic [NUM_CH-1:0]       cnt_overflow;

  ft_bus_stall_mon #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .wb_bus       (wb_bus),
    .ch_enable    (ch_enable),
    .cnt_clear    (cnt_clear),
    .bus_write    (bus_write),
    .bus_read     (bus_read),
    .bus_stall    (bus_stall),
    .freeze       (freeze),
    .stall_cnt    (stall_cnt),
    .xfer_cnt     (xfer_cnt),
    .max_run      (max_run),
    .cnt_overflow (cnt_overflow)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] scnt(input int ch);
    return 32'(stall_cnt[ch*CNT_W +: CNT_W]);
  endfunction
  function automatic logic [31:0] xcnt(input int ch);
    return 32'(xfer_cnt[ch*CNT_W +: CNT_W]);
  endfunction
  function automatic logic [31:0] mrun(input int ch);
    return 32'(max_run[ch*RUN_W +: RUN_W]);
  endfunction

  // Inputs change 1 time unit after the rising edge; samples are taken a unit later.
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_all();
    cnt_clear = 1'b1;
    next();
    cnt_clear = 1'b0;
  endtask

  // n_wait un-acked request cycles, then either an ack cycle or a dropped cyc,
  // then one idle cycle. Counts observed stall and freeze cycles.
  task automatic xact(input int ch, input int n_wait, input bit do_ack,
                      output int st, output int fz);
    st = 0;
    fz = 0;
    for (int i = 0; i < n_wait; i++) begin
      wb_bus.cyc[ch] = 1'b1;
      wb_bus.stb[ch] = 1'b1;
      wb_bus.ack[ch] = 1'b0;
      #1;
      if (bus_stall[ch]) st++;
      if (freeze) fz++;
      next();
    end
    if (do_ack) begin
      wb_bus.ack[ch] = 1'b1;
    end else begin
      wb_bus.cyc[ch] = 1'b0;
      wb_bus.stb[ch] = 1'b0;
    end
    #1;
    if (bus_stall[ch]) st++;
    if (freeze) fz++;
    next();
    wb_bus.cyc[ch] = 1'b0;
    wb_bus.stb[ch] = 1'b0;
    wb_bus.ack[ch] = 1'b0;
    next();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, fz;
    wb_bus.cyc = '0;
    wb_bus.stb = '0;
    wb_bus.ack = '0;
    wb_bus.we  = '0;
    ch_enable  = 2'b11;
    cnt_clear  = 1'b0;

    // Reset state and combinational decode while held in reset
    #12;
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_xfer_cnt",  32'(xfer_cnt), 0);
    check("rst_max_run",   32'(max_run), 0);
    check("rst_overflow",  32'(cnt_overflow), 0);
    wb_bus.cyc = 2'b10;
    wb_bus.stb = 2'b10;
    #1;
    check("rst_bus_read",  32'(bus_read), 2);
    check("rst_bus_write", 32'(bus_write), 0);
    check("rst_bus_stall", 32'(bus_stall), 0);
    check("rst_freeze",    32'(freeze), 0);
    wb_bus.we = 2'b10;
    #1;
    check("rst_bus_write_we", 32'(bus_write), 2);
    check("rst_bus_read_we",  32'(bus_read), 0);
    wb_bus.cyc = '0;
    wb_bus.stb = '0;
    wb_bus.we  = '0;
    @(negedge clock);
    reset_n = 1'b1;
    next();

    // Four un-acked cycles then ack on ch0
    xact(0, 4, 1'b1, st, fz);
    check("ack4_stall_seen",  st, 3);
    check("ack4_freeze_seen", fz, 3);
    check("ack4_stall_cnt0",  scnt(0), 3);
    check("ack4_xfer_cnt0",   xcnt(0), 1);
    check("ack4_max_run0",    mrun(0), 3);
    check("ack4_stall_cnt1",  scnt(1), 0);

    // Ch1 aborts after five un-acked cycles
    xact(1, 5, 1'b0, st, fz);
    check("abort_stall_seen", st, 4);
    check("abort_stall_cnt1", scnt(1), 4);
    check("abort_xfer_cnt1",  xcnt(1), 0);
    check("abort_max_run1",   mrun(1), 4);
    wb_bus.cyc[1] = 1'b1;
    #1;
    check("abort_fsm_idle", 32'(bus_stall[1]), 0);
    next();
    check("abort_fsm_idle_hold", 32'(bus_stall[1]), 0);
    wb_bus.cyc[1] = 1'b0;

    // Clear, then a disabled 6-cycle stall on ch0
    clear_all();
    check("clr_stall_cnt", 32'(stall_cnt), 0);
    check("clr_max_run",   32'(max_run), 0);
    check("clr_xfer_cnt",  32'(xfer_cnt), 0);
    ch_enable = 2'b10;
    xact(0, 7, 1'b1, st, fz);
    check("dis_stall_seen",  st, 6);
    check("dis_freeze_seen", fz, 0);
    check("dis_stall_cnt0",  scnt(0), 0);
    check("dis_xfer_cnt0",   xcnt(0), 0);
    check("dis_max_run0",    mrun(0), 0);
    ch_enable = 2'b11;

    // Simultaneous requests on both channels
    wb_bus.cyc = 2'b11;
    wb_bus.stb = 2'b11;
    wb_bus.we  = 2'b01;
    #1;
    check("sim_bus_write", 32'(bus_write), 1);
    check("sim_bus_read",  32'(bus_read), 2);
    next();
    next();
    next();
    wb_bus.ack = 2'b11;
    next();
    wb_bus.cyc = '0;
    wb_bus.stb = '0;
    wb_bus.ack = '0;
    wb_bus.we  = '0;
    next();
    check("sim_stall_cnt0", scnt(0), 2);
    check("sim_stall_cnt1", scnt(1), 2);
    check("sim_xfer_cnt0",  xcnt(0), 1);
    check("sim_xfer_cnt1",  xcnt(1), 1);

    // Runs of 2, 5, 3 on ch0
    clear_all();
    xact(0, 3, 1'b1, st, fz);
    check("runs_max_after2", mrun(0), 2);
    xact(0, 6, 1'b1, st, fz);
    xact(0, 4, 1'b1, st, fz);
    check("runs_max_run0",   mrun(0), 5);
    check("runs_stall_cnt0", scnt(0), 10);
    check("runs_xfer_cnt0",  xcnt(0), 3);

    // 17 stall cycles saturate the 4-bit counter
    clear_all();
    wb_bus.cyc[0] = 1'b1;
    wb_bus.stb[0] = 1'b1;
    repeat (18) next();
    check("sat_stall_cnt0", scnt(0), 15);
    check("sat_overflow0",  32'(cnt_overflow[0]), 1);
    check("sat_overflow1",  32'(cnt_overflow[1]), 0);
    check("sat_max_run0",   mrun(0), 17);

    // Clear wins over a concurrent stall, counting resumes next cycle
    cnt_clear = 1'b1;
    next();
    cnt_clear = 1'b0;
    check("clrpri_stall_cnt0", scnt(0), 0);
    check("clrpri_overflow0",  32'(cnt_overflow[0]), 0);
    check("clrpri_max_run0",   mrun(0), 0);
    check("clrpri_stall_live", 32'(bus_stall[0]), 1);
    next();
    check("clrpri_resume_cnt0", scnt(0), 1);
    check("clrpri_resume_run0", mrun(0), 1);

    // Asynchronous reset in the middle of a run, request held throughout
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_stall",     32'(bus_stall), 0);
    check("arst_freeze",    32'(freeze), 0);
    check("arst_stall_cnt", scnt(0), 0);
    check("arst_max_run",   mrun(0), 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("arst_rel_no_stall", 32'(bus_stall[0]), 0);
    next();
    check("arst_reassert", 32'(bus_stall[0]), 1);
    check("arst_cnt_first", scnt(0), 0);
    next();
    check("arst_cnt_second", scnt(0), 1);
    wb_bus.ack[0] = 1'b1;
    next();
    wb_bus.cyc = '0;
    wb_bus.stb = '0;
    wb_bus.ack = '0;
    next();
    check("arst_xfer_end", xcnt(0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
